// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART TX arbiter slice.
//               Provides the arbiter FSM state encoding and the UART byte
//               width used by the interface and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SEND  = 2'd1,
        ARB_ACK   = 2'd2,
        ARB_DRAIN = 2'd3
    } uart_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester-side byte streams plus the UART TX handshake.
//               slave  : the arbiter (consumes requests, drives the UART)
//               master : the environment (requesters and the UART itself)
// Signals     : req_valid/req_data/req_last/req_ready - per-requester stream
//               uart_tx_start/uart_tx_data/uart_tx_busy - UART TX handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import uart_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*UART_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           uart_tx_start;
    logic [UART_DATA_W-1:0]         uart_tx_data;
    logic                           uart_tx_busy;

    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, uart_tx_start, uart_tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, uart_tx_start, uart_tx_data
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority pick. The search starts at
//               the index just after ptr and wraps, so the requester at ptr
//               has the lowest priority.
// Ports       : req     in  N       request vector
//               ptr     in  log2(N) last-served index
//               gnt_idx out log2(N) winning index (0 when none)
//               any     out 1       at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] w_idx;

    // Walk from the farthest offset down to the nearest one so that the
    // closest valid requester after ptr is the last (winning) assignment.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = '0;
        for (int off = N; off >= 1; off--) begin
            w_idx = IW'((int'(ptr) + off) % N);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                any     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NUM_REQ byte streams with
//               round-robin arbitration. A grant is held for a whole packet
//               (until req_last) or until MAX_BURST bytes (0 = unlimited),
//               and the tx_start/tx_busy handshake is sequenced so that no
//               byte overlaps another.
// Ports       : clk, rst_n          clock, async active-low reset
//               bus (slave)         request streams + UART TX handshake
//               grant_active        a requester owns the UART
//               grant_id            owner index (valid with grant_active)
//               err_ack             pulse: UART never raised busy
//               sent_count          bytes handed to the UART (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 0,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_arbiter_if.slave           bus,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_ack,
    output logic [CNT_W-1:0]           sent_count
);

    localparam int c_ID_W    = $clog2(NUM_REQ);
    localparam int c_BURST_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam int c_TMR_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    uart_arb_state_t          r_state;
    logic [c_ID_W-1:0]        r_ptr;
    logic [c_ID_W-1:0]        r_grant_id;
    logic                     r_grant_active;
    logic [c_BURST_W-1:0]     r_burst_cnt;
    logic [c_TMR_W-1:0]       r_timer;
    logic                     r_last_q;
    logic                     r_tx_start;
    logic [UART_DATA_W-1:0]   r_tx_data;
    logic                     r_err_ack;
    logic [CNT_W-1:0]         r_sent_count;

    logic [c_ID_W-1:0]        w_win;
    logic                     w_any;
    logic [NUM_REQ-1:0]       w_ready;
    logic                     w_xfer;
    logic [UART_DATA_W-1:0]   w_byte;
    logic                     w_burst_done;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_win),
        .any     (w_any)
    );

    // Only the owner can be ready, and only while the UART is idle, so a
    // byte is never accepted that could not be started on the next cycle.
    always_comb begin
        w_ready = '0;
        if (r_state == ARB_SEND) begin
            w_ready[r_grant_id] = bus.req_valid[r_grant_id] & ~bus.uart_tx_busy;
        end
    end

    assign w_xfer       = w_ready[r_grant_id];
    assign w_byte       = bus.req_data[UART_DATA_W*int'(r_grant_id) +: UART_DATA_W];
    assign w_burst_done = (MAX_BURST != 0) && (r_burst_cnt == c_BURST_W'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ARB_IDLE;
            r_ptr          <= c_ID_W'(NUM_REQ - 1);
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_burst_cnt    <= '0;
            r_timer        <= '0;
            r_last_q       <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= '0;
            r_err_ack      <= 1'b0;
            r_sent_count   <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_err_ack  <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant_id     <= w_win;
                        r_grant_active <= 1'b1;
                        r_burst_cnt    <= '0;
                        r_state        <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    // Owner dropping valid mid-packet keeps the lock here.
                    if (w_xfer) begin
                        r_tx_start   <= 1'b1;
                        r_tx_data    <= w_byte;
                        r_last_q     <= bus.req_last[r_grant_id];
                        r_burst_cnt  <= r_burst_cnt + c_BURST_W'(1);
                        r_sent_count <= r_sent_count + CNT_W'(1);
                        r_timer      <= '0;
                        r_state      <= ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    if (bus.uart_tx_busy) begin
                        r_state <= ARB_DRAIN;
                    end else if (r_timer == c_TMR_W'(ACK_TIMEOUT - 1)) begin
                        r_err_ack      <= 1'b1;
                        r_grant_active <= 1'b0;
                        r_ptr          <= r_grant_id;
                        r_state        <= ARB_IDLE;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                ARB_DRAIN: begin
                    if (!bus.uart_tx_busy) begin
                        if (r_last_q || w_burst_done) begin
                            // Released owner becomes lowest priority next time.
                            r_grant_active <= 1'b0;
                            r_ptr          <= r_grant_id;
                            r_state        <= ARB_IDLE;
                        end else begin
                            r_state <= ARB_SEND;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.uart_tx_start = r_tx_start;
    assign bus.uart_tx_data  = r_tx_data;
    assign grant_active      = r_grant_active;
    assign grant_id          = r_grant_id;
    assign err_ack           = r_err_ack;
    assign sent_count        = r_sent_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench. dut0 has unlimited bursts and a 16-bit
//               counter; dut1 has MAX_BURST=2 and a 3-bit counter so that
//               wrap-around is reachable. A cycle task drives requester
//               queues, models the UART busy line and logs every tx_start;
//               scenario tasks compare the log against expected queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BUSY_LEN = 3;
    localparam int ACK_TO   = 8;

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  gid;
        logic [7:0]  data;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [N-1:0]   valid_d [2];
    logic [N-1:0]   last_d  [2];
    logic [N*8-1:0] data_d  [2];
    logic           busy_d  [2];

    wire [N-1:0]  ready_o [2];
    wire          start_o [2];
    wire [7:0]    txd_o   [2];
    wire          ga_o    [2];
    wire [1:0]    gid_o   [2];
    wire          err_o   [2];
    wire [15:0]   cnt_o   [2];
    wire [15:0]   cnt0;
    wire [2:0]    cnt1;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus0 ();
    uart_tx_arbiter_if #(.NUM_REQ(N)) bus1 ();

    assign bus0.req_valid    = valid_d[0];
    assign bus0.req_last     = last_d[0];
    assign bus0.req_data     = data_d[0];
    assign bus0.uart_tx_busy = busy_d[0];
    assign bus1.req_valid    = valid_d[1];
    assign bus1.req_last     = last_d[1];
    assign bus1.req_data     = data_d[1];
    assign bus1.uart_tx_busy = busy_d[1];

    assign ready_o[0] = bus0.req_ready;
    assign start_o[0] = bus0.uart_tx_start;
    assign txd_o[0]   = bus0.uart_tx_data;
    assign ready_o[1] = bus1.req_ready;
    assign start_o[1] = bus1.uart_tx_start;
    assign txd_o[1]   = bus1.uart_tx_data;
    assign cnt_o[0]   = cnt0;
    assign cnt_o[1]   = {13'd0, cnt1};

    uart_tx_arbiter #(
        .NUM_REQ(N), .MAX_BURST(0), .ACK_TIMEOUT(ACK_TO), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .grant_active(ga_o[0]), .grant_id(gid_o[0]),
        .err_ack(err_o[0]), .sent_count(cnt0)
    );

    uart_tx_arbiter #(
        .NUM_REQ(N), .MAX_BURST(2), .ACK_TIMEOUT(ACK_TO), .CNT_W(3)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .grant_active(ga_o[1]), .grant_id(gid_o[1]),
        .err_ack(err_o[1]), .sent_count(cnt1)
    );

    logic [8:0]  src_q [2*N][$];   // {last, data} per (dut, requester)
    logic [9:0]  exp_q [2][$];     // {grant_id, data} in expected order
    obs_t        obs_q [2][$];
    logic [N-1:0] xfer [2];
    int          busy_left [2];
    logic        mute [2];
    int unsigned cyc;
    int          rdy_cnt [2][N];
    int unsigned rdy_first [2][N];
    int          err_cnt [2];
    int unsigned err_cyc [2];
    logic        err_ga [2];
    int          viol [2];
    int          vectors;
    int          miscompares;

    // One clock cycle: sample outputs, update the UART model and the
    // requester drivers at the falling edge, then sample ready.
    task automatic tick();
        logic [N-1:0]   v, l;
        logic [N*8-1:0] d;
        logic [8:0]     f;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (start_o[k]) begin
                if (busy_d[k]) viol[k]++;
                obs_q[k].push_back(obs_t'{cyc, gid_o[k], txd_o[k]});
                if (!mute[k]) busy_left[k] = BUSY_LEN;
            end
            if (err_o[k]) begin
                err_cnt[k]++;
                err_cyc[k] = cyc;
                err_ga[k]  = ga_o[k];
            end
            for (int i = 0; i < N; i++)
                if (xfer[k][i] && src_q[k*N+i].size() > 0)
                    void'(src_q[k*N+i].pop_front());
            busy_d[k] = (busy_left[k] != 0);
            if (busy_left[k] != 0) busy_left[k]--;
            v = '0; l = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                if (src_q[k*N+i].size() > 0) begin
                    f = src_q[k*N+i][0];
                    v[i] = 1'b1;
                    l[i] = f[8];
                    d[8*i +: 8] = f[7:0];
                end
            end
            valid_d[k] = v;
            last_d[k]  = l;
            data_d[k]  = d;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            xfer[k] = valid_d[k] & ready_o[k];
            if ($countones(ready_o[k]) > 1) viol[k]++;
            for (int i = 0; i < N; i++) begin
                if (ready_o[k][i]) begin
                    if (rdy_cnt[k][i] == 0) rdy_first[k][i] = cyc;
                    rdy_cnt[k][i]++;
                end
            end
        end
    endtask

    task automatic push_src(input int k, input int i, input logic [7:0] d, input logic last);
        src_q[k*N+i].push_back({last, d});
    endtask

    task automatic push_exp(input int k, input logic [1:0] id, input logic [7:0] d);
        exp_q[k].push_back({id, d});
    endtask

    task automatic wait_obs(input int k, input int n, input int budget, output bit ok);
        int t = 0;
        while (obs_q[k].size() < n && t < budget) begin
            tick();
            t++;
        end
        ok = (obs_q[k].size() >= n);
    endtask

    task automatic wait_idle(input int k, input int budget, output bit ok);
        int  t = 0;
        bit  pend;
        pend = 1'b1;
        while (pend && t < budget) begin
            tick();
            t++;
            pend = ga_o[k] || busy_d[k];
            for (int i = 0; i < N; i++)
                if (src_q[k*N+i].size() > 0) pend = 1'b1;
        end
        ok = !pend;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({ready_o[k], start_o[k], txd_o[k], ga_o[k], gid_o[k], err_o[k], cnt_o[k]} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: got ready=%b start=%b data=%h ga=%b id=%0d err=%b cnt=%0d, want all 0",
                         k, ready_o[k], start_o[k], txd_o[k], ga_o[k], gid_o[k], err_o[k], cnt_o[k]);
            end
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        bit ok;
        int unsigned c0;
        obs_t o;
        logic [9:0] e;
        rdy_cnt[0][0] = 0;
        push_src(0, 0, 8'hA5, 1'b1);
        push_exp(0, 2'd0, 8'hA5);
        tick();
        c0 = cyc;
        wait_obs(0, 1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_timeout: got %0d starts, want 1", obs_q[0].size());
        end else begin
            o = obs_q[0].pop_front();
            e = exp_q[0].pop_front();
            vectors++;
            if ({o.gid, o.data} !== e) begin
                miscompares++;
                $display("FAIL single_byte: got id=%0d data=%h, want id=%0d data=%h", o.gid, o.data, e[9:8], e[7:0]);
            end
            vectors++;
            if (o.cyc - c0 != 2) begin
                miscompares++;
                $display("FAIL single_latency: got %0d cycles, want 2", o.cyc - c0);
            end
        end
        wait_idle(0, 40, ok);
        vectors++;
        if (rdy_cnt[0][0] != 1 || rdy_first[0][0] != c0 + 1) begin
            miscompares++;
            $display("FAIL single_ready: got %0d cycles at offset %0d, want 1 at offset 1",
                     rdy_cnt[0][0], rdy_first[0][0] - c0);
        end
        vectors++;
        if (!ok || cnt_o[0] !== 16'd1) begin
            miscompares++;
            $display("FAIL single_count: got idle=%0b cnt=%0d, want idle=1 cnt=1", ok, cnt_o[0]);
        end
    endtask

    task automatic test_packets();
        bit ok;
        obs_t o [6];
        logic [9:0] e;
        for (int b = 0; b < 3; b++) begin
            push_src(0, 1, 8'h11 + 8'(b), b == 2);
            push_src(0, 2, 8'h21 + 8'(b), b == 2);
        end
        for (int b = 0; b < 3; b++) push_exp(0, 2'd1, 8'h11 + 8'(b));
        for (int b = 0; b < 3; b++) push_exp(0, 2'd2, 8'h21 + 8'(b));
        wait_obs(0, 6, 300, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL packets_timeout: got %0d starts, want 6", obs_q[0].size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                o[j] = obs_q[0].pop_front();
                e = exp_q[0].pop_front();
                vectors++;
                if ({o[j].gid, o[j].data} !== e) begin
                    miscompares++;
                    $display("FAIL packets_byte%0d: got id=%0d data=%h, want id=%0d data=%h",
                             j, o[j].gid, o[j].data, e[9:8], e[7:0]);
                end
            end
            vectors++;
            if (o[1].cyc - o[0].cyc != BUSY_LEN + 2) begin
                miscompares++;
                $display("FAIL back_to_back_gap: got %0d cycles, want %0d", o[1].cyc - o[0].cyc, BUSY_LEN + 2);
            end
        end
        wait_idle(0, 60, ok);
        vectors++;
        if (!ok || cnt_o[0] !== 16'd7) begin
            miscompares++;
            $display("FAIL packets_count: got idle=%0b cnt=%0d, want idle=1 cnt=7", ok, cnt_o[0]);
        end
    endtask

    task automatic test_rotation();
        bit ok;
        obs_t o;
        logic [9:0] e;
        for (int i = 0; i < N; i++) begin
            push_src(1, i, 8'h40 + 8'(i), 1'b1);
            push_src(1, i, 8'h50 + 8'(i), 1'b1);
        end
        for (int i = 0; i < N; i++) push_exp(1, 2'(i), 8'h40 + 8'(i));
        for (int i = 0; i < N; i++) push_exp(1, 2'(i), 8'h50 + 8'(i));
        wait_obs(1, 8, 400, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rotation_timeout: got %0d starts, want 8", obs_q[1].size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                o = obs_q[1].pop_front();
                e = exp_q[1].pop_front();
                vectors++;
                if ({o.gid, o.data} !== e) begin
                    miscompares++;
                    $display("FAIL rotation_byte%0d: got id=%0d data=%h, want id=%0d data=%h",
                             j, o.gid, o.data, e[9:8], e[7:0]);
                end
            end
        end
        wait_idle(1, 60, ok);
        vectors++;
        if (!ok || cnt_o[1] !== 16'd0) begin
            miscompares++;
            $display("FAIL count_wrap: got idle=%0b cnt=%0d, want idle=1 cnt=0", ok, cnt_o[1]);
        end
    endtask

    task automatic test_burst();
        bit ok;
        obs_t o;
        logic [9:0] e;
        for (int b = 0; b < 5; b++) push_src(1, 0, 8'h60 + 8'(b), b == 4);
        push_src(1, 3, 8'h70, 1'b1);
        push_exp(1, 2'd0, 8'h60);
        push_exp(1, 2'd0, 8'h61);
        push_exp(1, 2'd3, 8'h70);
        push_exp(1, 2'd0, 8'h62);
        push_exp(1, 2'd0, 8'h63);
        push_exp(1, 2'd0, 8'h64);
        wait_obs(1, 6, 300, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL burst_timeout: got %0d starts, want 6", obs_q[1].size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                o = obs_q[1].pop_front();
                e = exp_q[1].pop_front();
                vectors++;
                if ({o.gid, o.data} !== e) begin
                    miscompares++;
                    $display("FAIL burst_byte%0d: got id=%0d data=%h, want id=%0d data=%h",
                             j, o.gid, o.data, e[9:8], e[7:0]);
                end
            end
        end
        wait_idle(1, 60, ok);
        vectors++;
        if (!ok || cnt_o[1] !== 16'd6) begin
            miscompares++;
            $display("FAIL burst_count: got idle=%0b cnt=%0d, want idle=1 cnt=6", ok, cnt_o[1]);
        end
    endtask

    task automatic test_ack_timeout();
        bit ok;
        int t;
        obs_t o;
        logic [9:0] e;
        int unsigned ts;
        mute[0]    = 1'b1;
        err_cnt[0] = 0;
        push_src(0, 0, 8'h81, 1'b1);
        push_src(0, 1, 8'h82, 1'b1);
        push_exp(0, 2'd0, 8'h81);
        push_exp(0, 2'd1, 8'h82);
        wait_obs(0, 1, 20, ok);
        ts = ok ? obs_q[0][0].cyc : 0;
        t = 0;
        while (err_cnt[0] == 0 && t < 40) begin
            tick();
            t++;
        end
        mute[0] = 1'b0;
        vectors++;
        if (err_cnt[0] == 0) begin
            miscompares++;
            $display("FAIL err_ack_missing: got no pulse, want pulse %0d cycles after tx_start", ACK_TO);
        end else begin
            vectors++;
            if (err_cyc[0] - ts != ACK_TO || err_ga[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL err_ack_timing: got offset=%0d ga=%b, want offset=%0d ga=0",
                         err_cyc[0] - ts, err_ga[0], ACK_TO);
            end
        end
        wait_obs(0, 2, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL next_grant_timeout: got %0d starts, want 2", obs_q[0].size());
        end else begin
            for (int j = 0; j < 2; j++) begin
                o = obs_q[0].pop_front();
                e = exp_q[0].pop_front();
                vectors++;
                if ({o.gid, o.data} !== e) begin
                    miscompares++;
                    $display("FAIL timeout_byte%0d: got id=%0d data=%h, want id=%0d data=%h",
                             j, o.gid, o.data, e[9:8], e[7:0]);
                end
            end
        end
        wait_idle(0, 60, ok);
        vectors++;
        if (!ok || err_cnt[0] != 1 || cnt_o[0] !== 16'd9) begin
            miscompares++;
            $display("FAIL timeout_final: got idle=%0b pulses=%0d cnt=%0d, want idle=1 pulses=1 cnt=9",
                     ok, err_cnt[0], cnt_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        obs_t o;
        logic [9:0] e;
        for (int b = 0; b < 3; b++) push_src(0, 2, 8'h91 + 8'(b), b == 2);
        push_exp(0, 2'd2, 8'h91);
        wait_obs(0, 1, 30, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reset_mid_start: got %0d starts, want 1", obs_q[0].size());
        end else begin
            o = obs_q[0].pop_front();
            e = exp_q[0].pop_front();
            vectors++;
            if ({o.gid, o.data} !== e) begin
                miscompares++;
                $display("FAIL reset_mid_byte: got id=%0d data=%h, want id=%0d data=%h",
                         o.gid, o.data, e[9:8], e[7:0]);
            end
        end
        tick();   // arbiter now waits in DRAIN with busy high
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ready_o[0], start_o[0], txd_o[0], ga_o[0], gid_o[0], err_o[0], cnt_o[0]} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got ready=%b start=%b data=%h ga=%b id=%0d err=%b cnt=%0d, want all 0",
                     ready_o[0], start_o[0], txd_o[0], ga_o[0], gid_o[0], err_o[0], cnt_o[0]);
        end
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q[0].delete();
        xfer[0] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        vectors++;
        if (obs_q[0].size() != 0 || ga_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got %0d starts ga=%b, want 0 starts ga=0", obs_q[0].size(), ga_o[0]);
        end
        obs_q[0].delete();
        push_src(0, 1, 8'hA7, 1'b1);
        push_exp(0, 2'd1, 8'hA7);
        wait_obs(0, 1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reset_resume_timeout: got %0d starts, want 1", obs_q[0].size());
        end else begin
            o = obs_q[0].pop_front();
            e = exp_q[0].pop_front();
            vectors++;
            if ({o.gid, o.data} !== e || cnt_o[0] !== 16'd1) begin
                miscompares++;
                $display("FAIL reset_resume: got id=%0d data=%h cnt=%0d, want id=%0d data=%h cnt=1",
                         o.gid, o.data, cnt_o[0], e[9:8], e[7:0]);
            end
        end
        wait_idle(0, 40, ok);
    endtask

    task automatic test_protocol();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (viol[k] != 0) begin
                miscompares++;
                $display("FAIL protocol dut%0d: got %0d start-while-busy/multi-ready events, want 0", k, viol[k]);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 2; k++) begin
            valid_d[k]   = '0;
            last_d[k]    = '0;
            data_d[k]    = '0;
            busy_d[k]    = 1'b0;
            xfer[k]      = '0;
            busy_left[k] = 0;
            mute[k]      = 1'b0;
            err_cnt[k]   = 0;
            err_cyc[k]   = 0;
            err_ga[k]    = 1'b0;
            viol[k]      = 0;
            for (int i = 0; i < N; i++) begin
                rdy_cnt[k][i]   = 0;
                rdy_first[k][i] = 0;
            end
        end
        test_reset();
        test_single();
        test_packets();
        test_rotation();
        test_burst();
        test_ack_timeout();
        test_reset_mid();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
